// File: rtl/burst_beat_source_if.sv
// Request and beat-enqueue method bundle around burst_beat_source.
// No logic; carries the req/start and out/enq method signals.
// slave is the burst source's view, master is the surrounding logic's view.
interface burst_beat_source_if;
    // request method: payload {addr[14:10], len[9:6], id[5:0]}
    logic        req_start_ena;
    logic [14:0] req_start_v;
    logic        req_start_rdy;
    // beat enqueue method: payload {addr[15:11], count[10:7], id[6:1], last[0]}
    logic        out_enq_ena;
    logic [15:0] out_enq_v;
    logic        out_enq_rdy;

    modport slave (
        input  req_start_ena,
        input  req_start_v,
        input  out_enq_rdy,
        output req_start_rdy,
        output out_enq_ena,
        output out_enq_v
    );

    modport master (
        output req_start_ena,
        output req_start_v,
        output out_enq_rdy,
        input  req_start_rdy,
        input  out_enq_ena,
        input  out_enq_v
    );
endinterface

// File: rtl/burst_beat_source.sv
// Expands one burst request into a stream of addressed, numbered beats.
// First beat offered the cycle after the request is taken; one beat per cycle.
// Downstream RDY low stalls the burst with payload held; requests blocked while busy.
module burst_beat_source #(
    parameter int ADDR_STRIDE = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    burst_beat_source_if.slave          bus,
    output logic                        busy,
    output logic [7:0]                  bursts_done
);

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] len;
        logic [5:0] id;
    } req_t;

    typedef struct packed {
        logic [4:0] addr;
        logic [3:0] count;
        logic [5:0] id;
        logic       last;
    } beat_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // stride folded into the 5-bit address space so the add wraps naturally
    localparam logic [4:0] STRIDE5 = 5'(ADDR_STRIDE % 32);

    state_t     state_q, state_d;
    logic [4:0] cur_addr;
    logic [3:0] cur_idx;
    logic [3:0] last_idx;
    logic [5:0] cur_id;

    req_t       req;
    beat_t      beat;
    logic       accept;
    logic       step;
    logic       finish;
    logic       req_rdy;
    logic       enq_ena;
    logic       in_burst;

    assign req = req_t'(bus.req_start_v);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, method readiness, beat payload and datapath controls
    always_comb begin
        state_d  = state_q;
        req_rdy  = 1'b0;
        enq_ena  = 1'b0;
        in_burst = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        finish   = 1'b0;
        beat     = '0;
        case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_start_ena) begin
                    accept  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                in_burst   = 1'b1;
                // ENA follows RDY directly so a beat is never offered unready
                enq_ena    = bus.out_enq_rdy;
                beat.addr  = cur_addr;
                beat.count = cur_idx;
                beat.id    = cur_id;
                beat.last  = (cur_idx == last_idx);
                if (enq_ena) begin
                    if (beat.last) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // burst context: loaded on accept, advanced on each non-final beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_addr <= '0;
            cur_idx  <= '0;
            last_idx <= '0;
            cur_id   <= '0;
        end else if (accept) begin
            cur_addr <= req.addr;
            cur_idx  <= '0;
            last_idx <= req.len;
            cur_id   <= req.id;
        end else if (step) begin
            cur_addr <= cur_addr + STRIDE5;
            cur_idx  <= cur_idx + 4'd1;
        end
    end

    // completed-burst counter, free-running 8-bit wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            bursts_done <= '0;
        end else if (finish) begin
            bursts_done <= bursts_done + 8'd1;
        end
    end

    assign bus.req_start_rdy = req_rdy;
    assign bus.out_enq_ena   = enq_ena;
    assign bus.out_enq_v     = beat;
    assign busy              = in_burst;

endmodule
